vga_fb_arbiter: RTL and testbench
=================================

// Module: vga_fb_arbiter
// PURPOSE
//  Sole owner of the single-port pixel framebuffer (640x480, 3-bit RGB per word).
//  Shares it between two requesters: the scanout path (reads, real-time) and the game/draw logic (writes).
//  Scanout reads are prefetched into a small FIFO; the VGA timing generator pops one pixel per active-display clock.
//  Draw writes are slotted in whenever the FIFO is safely full, and during blanking.
// PARAMETERS
//  H_DISPLAY   640  active pixels per line
//  V_DISPLAY   480  active lines per frame
//  ADDR_W      19   framebuffer address width (ceil(log2(H_DISPLAY*V_DISPLAY)))
//  FIFO_DEPTH  16   prefetch FIFO depth, power of 2, >= 4
//  LOW_WM      4    below this occupancy, fetch beats a pending write
// PORTS
//  clk          in   1       pixel clock, all logic on posedge
//  rst_n        in   1       asynchronous active-low reset
//  frame_start  in   1       1-cycle pulse at start of frame; restarts fetch at address 0
//  pix_pop      in   1       scanout consumes one pixel this cycle
//  pix_rgb      out  3       FIFO head pixel {r,g,b}; 3'b000 when empty
//  pix_valid    out  1       FIFO non-empty
//  underflow    out  1       1-cycle pulse: pix_pop while FIFO empty
//  wr_req       in   1       draw write request, held with addr/data until wr_ack
//  wr_addr      in   ADDR_W  draw write address (linear, y*H_DISPLAY+x)
//  wr_rgb       in   3       draw write data
//  wr_ack       out  1       1-cycle pulse, same cycle the write is on mem_*
//  mem_en       out  1       framebuffer access enable
//  mem_we       out  1       1 = write, 0 = read
//  mem_addr     out  ADDR_W  framebuffer address
//  mem_wdata    out  3       framebuffer write data
//  mem_rdata    in   3       read data, valid 1 cycle after a read on mem_*
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, fetch_addr=0, state IDLE, no read in flight.
//  - One memory op per cycle. mem_*, wr_ack registered; decision in cycle t appears on mem_* in t+1,
//    read data captured into FIFO at end of t+2. Pop-to-next-head latency 0 (pix_rgb = head).
//  - occ = fifo_count + reads_in_flight (0..2). room = occ < FIFO_DEPTH. more = fetch_addr < H_DISPLAY*V_DISPLAY.
//  - Arbitration each cycle, FSM states IDLE/FETCH/WRITE = op issued next cycle:
//      FETCH if more && room && (occ < LOW_WM || !wr_req);
//      WRITE if wr_req && !(more && occ < LOW_WM) && not acked last cycle;
//      else IDLE (mem_en=0).
//  - FETCH: mem_addr=fetch_addr, fetch_addr++. fetch_addr saturates at H_DISPLAY*V_DISPLAY (no wrap) until frame_start.
//  - WRITE: mem_we=1, wr_ack=1 for exactly one cycle; requester sees ack and may present a new request next cycle
//    (a req still high in the ack cycle is not re-granted for the same beat).
//  - Push and pop same cycle: count unchanged. Pop when empty: no state change, pix_rgb=0, underflow=1.
//  - Push when full cannot occur (room accounting); a bench assertion checks it.
//  - frame_start (any state, any cycle): flush FIFO, fetch_addr=0, discard any read in flight
//    (its data is not pushed); a write already issued completes and is acked normally; arbitration resumes next cycle.
//  - wr_addr >= H_DISPLAY*V_DISPLAY: write is acked but mem_en held 0 (dropped).
// CONFIGURATION
//  FB_UNDERFLOW_CNT_EN defined: extra output underflow_cnt [15:0], counts underflow pulses, saturates at 16'hFFFF,
//    cleared by reset only. Undefined: port absent, no counter logic; underflow pulse unchanged.
// STRUCTURE
//  - Shared package/include vga_pkg: H_DISPLAY, V_DISPLAY, H/V porch and sync constants, ADDR_W, FB_WORDS,
//    rgb_t (3-bit), arbiter state encoding.
//  - One sub-module: vga_pix_fifo (sync FIFO, DEPTH param, push/pop/count/empty/full, flush input).
// TESTING
//  1 Reset mid-frame: rst_n low 1 cycle -> all outputs 0, pix_valid=0 next cycle, first mem read at addr 0 after frame_start.
//  2 Fill: frame_start, no pops, no writes -> reads addr 0..15 back-to-back, then mem_en=0; pix_valid=1, count 16.
//  3 Write under load: FIFO at 16, wr_req addr 1000 rgb 3'b101 -> mem_we=1 addr 1000 next cycle, wr_ack pulse same cycle.
//  4 Priority: occ=3, wr_req held, pix_pop each cycle -> fetches issued, wr_ack withheld until occ>=LOW_WM.
//  5 Underflow: pix_pop with FIFO empty -> pix_rgb=0, underflow=1 one cycle (+underflow_cnt=1 with FB_UNDERFLOW_CNT_EN).
//  6 frame_start with read in flight, addr 5000 -> FIFO empty next cycle, stale data not pushed, next read addr 0.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA constants, framebuffer geometry, pixel type and arbiter state encoding.
package vga_pkg;
  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam int ADDR_W       = 19;
  localparam int FB_WORDS_INT = H_DISPLAY * V_DISPLAY;
  localparam logic [ADDR_W-1:0] FB_WORDS = ADDR_W'(FB_WORDS_INT);

  typedef logic [2:0] rgb_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WRITE = 2'd2
  } arb_state_t;
endpackage

// File: rtl/vga_pix_fifo.sv
// Synchronous pixel prefetch FIFO with flush; head word is visible combinationally.
module vga_pix_fifo
  import vga_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  rgb_t                     wdata,
  input  logic                     pop,
  output rgb_t                     rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  rgb_t            mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  assign rdata   = empty ? '0 : mem_q[rd_ptr_q];
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end
endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: scanout prefetch vs. draw writes.
// Optional FB_UNDERFLOW_CNT_EN adds a saturating underflow_cnt output.
//
//   state    | meaning (op on mem_* in the cycle after the decision)
//   ST_IDLE  | no access, mem_en = 0
//   ST_FETCH | scanout read at fetch_addr
//   ST_WRITE | draw write (acked; dropped on the bus if address out of range)
module vga_fb_arbiter
  import vga_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LOW_WM     = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_pop,
  output logic [2:0]        pix_rgb,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [2:0]        wr_rgb,
  output logic              wr_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [2:0]        mem_wdata,
  input  logic [2:0]        mem_rdata
`ifdef FB_UNDERFLOW_CNT_EN
  ,
  output logic [15:0]       underflow_cnt
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(FIFO_DEPTH);
  localparam logic [OW-1:0] LOW_O   = OW'(LOW_WM);

  arb_state_t        state_q, state_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic              rd_ret_q, rd_ret_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  rgb_t              mem_wdata_q, mem_wdata_d;
  logic              wr_ack_q, wr_ack_d;

  logic [CW-1:0]     fifo_count;
  logic              fifo_empty, fifo_full, fifo_push;
  rgb_t              fifo_rdata;
  logic              rd_issue;
  logic [OW-1:0]     occ;
  logic              room, more, low, wr_in_range;

  // A read on the bus now, and one whose data returns now, both hold a slot.
  assign rd_issue    = (state_q == ST_FETCH);
  assign occ         = OW'(fifo_count) + OW'(rd_issue) + OW'(rd_ret_q);
  assign room        = (occ < DEPTH_O) && !fifo_full;
  assign more        = (fetch_addr_q < FB_WORDS);
  assign low         = (occ < LOW_O);
  assign wr_in_range = (wr_addr < FB_WORDS);
  assign fifo_push   = rd_ret_q && !frame_start;

  always_comb begin
    state_d      = ST_IDLE;
    fetch_addr_d = fetch_addr_q;
    rd_ret_d     = rd_issue && !frame_start;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    wr_ack_d     = 1'b0;
    if (frame_start) begin
      fetch_addr_d = '0;
    end else if (more && room && (low || !wr_req)) begin
      state_d      = ST_FETCH;
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
      mem_en_d     = 1'b1;
      mem_addr_d   = fetch_addr_q;
    end else if (wr_req && !(more && low) && !wr_ack_q) begin
      state_d  = ST_WRITE;
      wr_ack_d = 1'b1;
      if (wr_in_range) begin
        mem_en_d    = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = wr_addr;
        mem_wdata_d = wr_rgb;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      fetch_addr_q <= '0;
      rd_ret_q     <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      wr_ack_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      rd_ret_q     <= rd_ret_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      wr_ack_q     <= wr_ack_d;
    end
  end

  vga_pix_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (frame_start),
    .push  (fifo_push),
    .wdata (mem_rdata),
    .pop   (pix_pop),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign pix_rgb   = fifo_rdata;
  assign pix_valid = !fifo_empty;
  assign underflow = pix_pop && fifo_empty;
  assign wr_ack    = wr_ack_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef FB_UNDERFLOW_CNT_EN
  logic [15:0] ucnt_q, ucnt_d;

  always_comb begin
    ucnt_d = ucnt_q;
    if (underflow && (ucnt_q != 16'hFFFF)) ucnt_d = ucnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ucnt_q <= '0;
    else        ucnt_q <= ucnt_d;
  end

  assign underflow_cnt = ucnt_q;
`endif
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Self-checking bench for vga_fb_arbiter: memory model plus pixel scoreboard.
module tb_vga_fb_arbiter;
  import vga_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame_start, pix_pop, wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_rgb;
  logic [2:0]        pix_rgb, mem_wdata, mem_rdata;
  logic              pix_valid, underflow, wr_ack, mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
`ifdef FB_UNDERFLOW_CNT_EN
  logic [15:0]       underflow_cnt;
`endif

  int   total = 0;
  int   bad   = 0;
  int   exp_ucnt = 0;
  rgb_t exp_q[$];
  logic [2:0] fb_w[int];

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_pop(pix_pop),
    .pix_rgb(pix_rgb), .pix_valid(pix_valid), .underflow(underflow),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_rgb(wr_rgb), .wr_ack(wr_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
`ifdef FB_UNDERFLOW_CNT_EN
    , .underflow_cnt(underflow_cnt)
`endif
  );

  function automatic logic [2:0] fb_init(int a);
    return 3'(a ^ (a >> 3) ^ (a >> 6));
  endfunction

  function automatic logic [2:0] fb_read(int a);
    if (fb_w.exists(a)) return fb_w[a];
    return fb_init(a);
  endfunction

  // Framebuffer model: read data valid the cycle after the read is on the bus.
  always @(posedge clk) begin
    if (mem_en && mem_we) fb_w[int'(mem_addr)] = mem_wdata;
    else if (mem_en)      mem_rdata <= fb_read(int'(mem_addr));
  end

  // Scoreboard: expected pixels queued when a read is seen on the bus.
  always @(negedge clk) begin
    rgb_t e;
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      total++;
      if (dut.fifo_push && dut.fifo_full) begin
        bad++;
        $display("FAIL push_when_full actual=1 required=0 t=%0t", $time);
      end
      if (frame_start) begin
        exp_q.delete();
      end else begin
        if (pix_pop && pix_valid) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL sb_pixel actual=%0h required=none t=%0t", pix_rgb, $time);
          end else begin
            e = exp_q.pop_front();
            if (pix_rgb !== e) begin
              bad++;
              $display("FAIL sb_pixel actual=%0h required=%0h t=%0t", pix_rgb, e, $time);
            end
          end
        end
        if (mem_en && !mem_we) exp_q.push_back(fb_read(int'(mem_addr)));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if ({mem_en, mem_we, wr_ack} !== 3'b000) begin bad++; $display("FAIL rst_mem_ctl actual=%0b required=000", {mem_en, mem_we, wr_ack}); end
    total++; if ({pix_valid, underflow, pix_rgb} !== 5'b0) begin bad++; $display("FAIL rst_pix actual=%0b required=0", {pix_valid, underflow, pix_rgb}); end
    total++; if ({mem_addr, mem_wdata} !== '0) begin bad++; $display("FAIL rst_mem_bus actual=%0h required=0", {mem_addr, mem_wdata}); end
    step();
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL rst_first_idle actual=%0b required=0", mem_en); end
    step();
    @(negedge clk);
    total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 19'd0}) begin bad++; $display("FAIL rst_first_read actual=%0b/%0b/%0d required=1/0/0", mem_en, mem_we, mem_addr); end
    repeat (30) step();
  endtask

  task automatic test_fill();
    int nreads = 0;
    step(); frame_start = 1'b1;
    step(); frame_start = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (mem_en && !mem_we) begin
        total++;
        if (mem_addr !== 19'(nreads) || k != nreads + 2) begin
          bad++;
          $display("FAIL fill_read actual=addr%0d@%0d required=addr%0d@%0d", mem_addr, k, nreads, nreads + 2);
        end
        nreads++;
      end
    end
    total++; if (nreads != 16) begin bad++; $display("FAIL fill_nreads actual=%0d required=16", nreads); end
    total++; if (pix_valid !== 1'b1) begin bad++; $display("FAIL fill_valid actual=%0b required=1", pix_valid); end
    total++; if (dut.fifo_count !== 5'd16) begin bad++; $display("FAIL fill_count actual=%0d required=16", dut.fifo_count); end
  endtask

  task automatic test_write_under_load();
    step(); wr_req = 1'b1; wr_addr = 19'd1000; wr_rgb = 3'b101;
    @(negedge clk);
    total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL wr_early_ack actual=%0b required=0", wr_ack); end
    step();
    @(negedge clk);
    total++; if ({wr_ack, mem_en, mem_we} !== 3'b111) begin bad++; $display("FAIL wr_issue actual=%0b required=111", {wr_ack, mem_en, mem_we}); end
    total++; if ({mem_addr, mem_wdata} !== {19'd1000, 3'b101}) begin bad++; $display("FAIL wr_bus actual=%0d/%0b required=1000/101", mem_addr, mem_wdata); end
    step(); wr_req = 1'b0;
    @(negedge clk);
    total++; if ({wr_ack, mem_en} !== 2'b00) begin bad++; $display("FAIL wr_pulse actual=%0b required=00", {wr_ack, mem_en}); end
    step(); wr_req = 1'b1; wr_addr = 19'd307200; wr_rgb = 3'b111;
    step();
    @(negedge clk);
    total++; if ({wr_ack, mem_en} !== 2'b10) begin bad++; $display("FAIL wr_drop actual=%0b required=10", {wr_ack, mem_en}); end
    step(); wr_req = 1'b0;
    @(negedge clk);
    total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL wr_drop_pulse actual=%0b required=0", wr_ack); end
  endtask

  task automatic test_priority();
    int  nfetch = 0;
    bit  got = 0;
    step(); frame_start = 1'b1; wr_req = 1'b1; wr_addr = 19'd2000; wr_rgb = 3'b011;
    step(); frame_start = 1'b0;
    for (int k = 0; k < 12; k++) begin
      pix_pop = pix_valid;
      @(negedge clk);
      total++; if (wr_ack !== 1'b0) begin bad++; $display("FAIL prio_ack_withheld actual=%0b required=0 k=%0d", wr_ack, k); end
      if (mem_en && !mem_we) nfetch++;
      step();
    end
    pix_pop = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (wr_ack) begin
        got = 1;
        total++; if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 19'd2000, 3'b011}) begin bad++; $display("FAIL prio_write_bus actual=%0b/%0d/%0b required=1/2000/011", mem_we, mem_addr, mem_wdata); end
      end
      step();
    end
    wr_req = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL prio_ack_timeout actual=none required=ack"); end
    total++; if (nfetch < 10) begin bad++; $display("FAIL prio_fetches actual=%0d required>=10", nfetch); end
  endtask

  task automatic test_underflow();
    step(); frame_start = 1'b1;
    step(); frame_start = 1'b0; pix_pop = 1'b1; exp_ucnt++;
    @(negedge clk);
    total++; if ({underflow, pix_valid, pix_rgb} !== 5'b10000) begin bad++; $display("FAIL uf_pulse actual=%0b required=10000", {underflow, pix_valid, pix_rgb}); end
    step(); pix_pop = 1'b0;
    @(negedge clk);
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL uf_one_cycle actual=%0b required=0", underflow); end
`ifdef FB_UNDERFLOW_CNT_EN
    total++; if (underflow_cnt !== 16'(exp_ucnt)) begin bad++; $display("FAIL uf_cnt actual=%0d required=%0d", underflow_cnt, exp_ucnt); end
`endif
  endtask

  task automatic test_frame_start_inflight();
    bit found = 0;
    for (int k = 0; k < 12000 && !found; k++) begin
      pix_pop = pix_valid;
      @(negedge clk);
      if (mem_en && !mem_we && mem_addr == 19'd5000) found = 1;
      step();
    end
    total++; if (!found) begin bad++; $display("FAIL fs_reach_5000 actual=none required=read5000"); end
    pix_pop = 1'b0; frame_start = 1'b1;
    step(); frame_start = 1'b0;
    @(negedge clk);
    total++; if ({pix_valid, mem_en} !== 2'b00) begin bad++; $display("FAIL fs_flush actual=%0b required=00", {pix_valid, mem_en}); end
    step();
    @(negedge clk);
    total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 19'd0}) begin bad++; $display("FAIL fs_restart actual=%0b/%0b/%0d required=1/0/0", mem_en, mem_we, mem_addr); end
    total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL fs_stale1 actual=%0b required=0", pix_valid); end
    step();
    @(negedge clk);
    total++; if (pix_valid !== 1'b0) begin bad++; $display("FAIL fs_stale2 actual=%0b required=0", pix_valid); end
    step();
    @(negedge clk);
    total++; if ({pix_valid, pix_rgb} !== {1'b1, fb_read(0)}) begin bad++; $display("FAIL fs_first_pixel actual=%0b/%0h required=1/%0h", pix_valid, pix_rgb, fb_read(0)); end
    for (int k = 0; k < 6; k++) begin
      step(); pix_pop = pix_valid;
    end
    step(); pix_pop = 1'b0;
  endtask

  task automatic test_midframe_reset();
    step(); rst_n = 1'b0; exp_ucnt = 0;
    @(negedge clk);
    total++; if ({mem_en, mem_we, wr_ack, pix_valid, underflow, pix_rgb} !== 8'b0) begin bad++; $display("FAIL mrst_out actual=%0b required=0", {mem_en, mem_we, wr_ack, pix_valid, underflow, pix_rgb}); end
`ifdef FB_UNDERFLOW_CNT_EN
    total++; if (underflow_cnt !== 16'(exp_ucnt)) begin bad++; $display("FAIL mrst_cnt actual=%0d required=0", underflow_cnt); end
`endif
    step(); rst_n = 1'b1;
    @(negedge clk);
    total++; if ({pix_valid, mem_en} !== 2'b00) begin bad++; $display("FAIL mrst_after actual=%0b required=00", {pix_valid, mem_en}); end
    step();
    @(negedge clk);
    total++; if ({mem_en, mem_addr} !== {1'b1, 19'd0}) begin bad++; $display("FAIL mrst_read0 actual=%0b/%0d required=1/0", mem_en, mem_addr); end
    step(); frame_start = 1'b1;
    step(); frame_start = 1'b0;
    @(negedge clk);
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL mrst_fs_idle actual=%0b required=0", mem_en); end
    step();
    @(negedge clk);
    total++; if ({mem_en, mem_we, mem_addr} !== {2'b10, 19'd0}) begin bad++; $display("FAIL mrst_fs_read0 actual=%0b/%0b/%0d required=1/0/0", mem_en, mem_we, mem_addr); end
    repeat (4) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; frame_start = 1'b0; pix_pop = 1'b0;
    wr_req = 1'b0; wr_addr = '0; wr_rgb = '0; mem_rdata = '0;
    test_reset();
    test_fill();
    test_write_under_load();
    test_priority();
    test_underflow();
    test_frame_start_inflight();
    test_midframe_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
